// File: rtl/maintenance_mode_controller.sv
// maintenance_mode_controller: sequences the dispenser output mux between normal and maintenance modes
module maintenance_mode_controller #(
  parameter int PIN_W = 4,
  parameter logic [PIN_W-1:0] PIN = 4'hA,
  parameter int MAX_TRIES = 3,
  parameter int TIMER_W = 16,
  parameter int PIN_TIMEOUT = 1000,
  parameter int SETTLE = 4,
  parameter int LOCKOUT_CYCLES = 5000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             maint_key,
  input  logic [PIN_W-1:0] pin_code,
  input  logic             pin_enter,
  input  logic             normal_busy,
  input  logic             maint_busy,
  output logic             select,
  output logic             hold_req,
  output logic             pin_error,
  output logic             lockout,
  output logic [2:0]       mode_state
);
  localparam int IW = $clog2(SETTLE + 1);
  typedef enum logic [2:0] {
    NORMAL    = 3'd0,
    WAIT_PIN  = 3'd1,
    DRAIN_IN  = 3'd2,
    MAINT     = 3'd3,
    DRAIN_OUT = 3'd4,
    LOCKOUT   = 3'd5
  } state_t;
  state_t state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0] tries_q, tries_d, tries_inc;
  logic [IW-1:0] idle_q, idle_d;
  logic key_q, rise, pin_ok;
  logic select_q, hold_req_q, pin_error_q, pin_error_d, lockout_q;
  assign rise = maint_key & ~key_q;
  assign pin_ok = pin_enter && (pin_code == PIN);
  assign tries_inc = tries_q + 3'd1;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tries_d = tries_q;
    idle_d = idle_q;
    pin_error_d = 1'b0;
    case (state_q)
      NORMAL: if (rise) begin
        state_d = WAIT_PIN;
        timer_d = TIMER_W'(PIN_TIMEOUT);
      end
      WAIT_PIN: if (pin_ok) begin
        state_d = DRAIN_IN;
        tries_d = 3'd0;
        idle_d = '0;
      end else if (pin_enter) begin
        pin_error_d = 1'b1;
        if (tries_inc == 3'(MAX_TRIES)) begin
          state_d = LOCKOUT;
          timer_d = TIMER_W'(LOCKOUT_CYCLES);
          tries_d = 3'd0;
        end else begin
          tries_d = tries_inc;
          timer_d = TIMER_W'(PIN_TIMEOUT);
        end
      end else if (!maint_key || timer_q == '0) state_d = NORMAL;
      else timer_d = timer_q - TIMER_W'(1);
      DRAIN_IN: if (!maint_key) state_d = NORMAL;
      else begin
        idle_d = normal_busy ? '0 : idle_q + IW'(1);
        state_d = (idle_d == IW'(SETTLE)) ? MAINT : DRAIN_IN;
      end
      MAINT: if (!maint_key) begin
        state_d = DRAIN_OUT;
        idle_d = '0;
      end
      DRAIN_OUT: begin
        idle_d = maint_busy ? '0 : idle_q + IW'(1);
        state_d = (idle_d == IW'(SETTLE)) ? NORMAL : DRAIN_OUT;
      end
      LOCKOUT: begin
        // the load value counts LOCKOUT cycles, so leave while the count still reads 1
        timer_d = (timer_q <= TIMER_W'(1)) ? '0 : timer_q - TIMER_W'(1);
        state_d = (timer_q <= TIMER_W'(1)) ? NORMAL : LOCKOUT;
      end
      default: state_d = NORMAL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NORMAL;
      timer_q <= '0;
      tries_q <= 3'd0;
      idle_q <= '0;
      key_q <= 1'b0;
      select_q <= 1'b0;
      hold_req_q <= 1'b0;
      pin_error_q <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tries_q <= tries_d;
      idle_q <= idle_d;
      key_q <= maint_key;
      select_q <= (state_d == MAINT) || (state_d == DRAIN_OUT);
      hold_req_q <= (state_d == DRAIN_IN) || (state_d == MAINT) || (state_d == DRAIN_OUT);
      pin_error_q <= pin_error_d;
      lockout_q <= (state_d == LOCKOUT);
    end
  end
  assign select = select_q;
  assign hold_req = hold_req_q;
  assign pin_error = pin_error_q;
  assign lockout = lockout_q;
  assign mode_state = state_q;
endmodule

// File: tb/tb_maintenance_mode_controller.sv
// tb_maintenance_mode_controller: directed + random stimulus, scoreboard against a behavioural model
module tb_maintenance_mode_controller;
  logic clk = 1'b0;
  logic reset, maint_key, pin_enter, normal_busy, maint_busy;
  logic [3:0] pin_code;
  logic select, hold_req, pin_error, lockout;
  logic [2:0] mode_state;
  int n_tests = 0;
  int n_fail = 0;
  int cycle = 0;
  logic [6:0] exp_q[$];
  int m_mode = 0, m_tries = 0, m_age = 0, m_quiet = 0;
  bit m_kp = 0, m_err = 0;

  maintenance_mode_controller dut (
    .clk(clk), .reset(reset), .maint_key(maint_key), .pin_code(pin_code),
    .pin_enter(pin_enter), .normal_busy(normal_busy), .maint_busy(maint_busy),
    .select(select), .hold_req(hold_req), .pin_error(pin_error),
    .lockout(lockout), .mode_state(mode_state)
  );

  always #5 clk = ~clk;

  // mode numbers follow the published encoding; ages count cycles spent, quiet counts idle cycles
  task automatic model_step();
    bit rise;
    rise = maint_key && !m_kp;
    m_err = 0;
    if (reset) begin
      m_mode = 0; m_tries = 0; m_age = 0; m_quiet = 0;
    end else begin
      case (m_mode)
        0: if (rise) begin m_mode = 1; m_age = 0; end
        1: if (pin_enter && pin_code == 4'hA) begin
             m_mode = 2; m_tries = 0; m_quiet = 0;
           end else if (pin_enter) begin
             m_err = 1; m_tries++; m_age = 0;
             if (m_tries == 3) begin m_mode = 5; m_tries = 0; end
           end else if (!maint_key) m_mode = 0;
           else if (m_age == 1000) m_mode = 0;
           else m_age++;
        2: if (!maint_key) m_mode = 0;
           else begin
             m_quiet = normal_busy ? 0 : m_quiet + 1;
             if (m_quiet == 4) m_mode = 3;
           end
        3: if (!maint_key) begin m_mode = 4; m_quiet = 0; end
        4: begin
             m_quiet = maint_busy ? 0 : m_quiet + 1;
             if (m_quiet == 4) m_mode = 0;
           end
        5: begin
             m_age++;
             if (m_age == 5000) begin m_mode = 0; m_age = 0; end
           end
        default: m_mode = 0;
      endcase
    end
    m_kp = reset ? 1'b0 : maint_key;
    exp_q.push_back({m_mode == 3 || m_mode == 4, m_mode >= 2 && m_mode <= 4,
                     m_err, m_mode == 5, 3'(m_mode)});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [6:0] e, g;
    @(posedge clk);
    #1;
    cycle++;
    g = {select, hold_req, pin_error, lockout, mode_state};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty cycle %0d: got %b", cycle, g);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got sel/hold/err/lock/mode=%b expected %b", cycle, g, e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] c);
    pin_code = c;
    pin_enter = 1'b1;
    cyc(1);
    pin_enter = 1'b0;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; maint_key = 1'b0; pin_enter = 1'b0; pin_code = 4'h0;
    normal_busy = 1'b0; maint_busy = 1'b0;
    cyc(3);
    chk("reset_mode", mode_state, 0);
    chk("reset_select", select, 0);
    reset = 1'b0;
    cyc(2);
    maint_key = 1'b1; cyc(1);
    strobe(4'hA);
    cyc(3);
    chk("entry_not_yet", select, 0);
    cyc(1);
    chk("entry_select", select, 1);
    chk("entry_mode", mode_state, 3);
    maint_busy = 1'b1; maint_key = 1'b0;
    cyc(10);
    chk("drain_out_busy_select", select, 1);
    maint_busy = 1'b0;
    cyc(3);
    chk("drain_out_settling", select, 1);
    cyc(1);
    chk("drain_out_done_select", select, 0);
    chk("drain_out_done_hold", hold_req, 0);
    maint_key = 1'b1; cyc(1);
    strobe(4'hA);
    cyc(3);
    normal_busy = 1'b1; cyc(1);
    normal_busy = 1'b0; cyc(3);
    chk("drain_in_restart", mode_state, 2);
    chk("drain_in_hold", hold_req, 1);
    cyc(1);
    chk("drain_in_maint", mode_state, 3);
    maint_key = 1'b0; cyc(6);
    maint_key = 1'b1; cyc(1);
    for (int i = 0; i < 3; i++) begin
      strobe(4'h3);
      chk("wrong_pin_pulse", pin_error, 1);
      cyc(2);
      chk("wrong_pin_pulse_end", pin_error, 0);
    end
    chk("lockout_on", lockout, 1);
    cyc(4995);
    chk("lockout_held", lockout, 1);
    cyc(5);
    chk("lockout_off", lockout, 0);
    cyc(5);
    chk("key_held_stays_normal", mode_state, 0);
    maint_key = 1'b0; cyc(2);
    maint_key = 1'b1; cyc(1);
    cyc(1000);
    chk("timeout_waiting", mode_state, 1);
    cyc(1);
    chk("timeout_normal", mode_state, 0);
    maint_key = 1'b0; cyc(1);
    maint_key = 1'b1; cyc(1);
    cyc(1000);
    strobe(4'hA);
    chk("pin_at_timer_zero", mode_state, 2);
    cyc(4);
    chk("maint_before_reset", mode_state, 3);
    reset = 1'b1; cyc(1);
    chk("reset_mid_select", select, 0);
    chk("reset_mid_hold", hold_req, 0);
    chk("reset_mid_mode", mode_state, 0);
    reset = 1'b0; maint_key = 1'b0; cyc(2);
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(39) == 0) maint_key = ~maint_key;
      pin_enter = ($urandom_range(7) == 0);
      pin_code = ($urandom_range(9) < 4) ? 4'hA : 4'($urandom);
      normal_busy = 1'($urandom);
      maint_busy = 1'($urandom);
      reset = ($urandom_range(1999) == 0);
      cyc(1);
    end
    reset = 1'b0; pin_enter = 1'b0;
    cyc(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
